decode_execute_seq: RTL and testbench



---
 rtl/decode_execute_seq_if.sv | 27 ++
 rtl/decode_execute_seq.sv | 110 +++++++++++
 tb/tb_decode_execute_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_execute_seq_if.sv
// Operation/result channel between the lab's operand source, decode_execute_seq and the result sink.
// Both channels transfer on a rising clk edge where valid and ready are both high; the side holding valid keeps its payload stable until then.
interface decode_execute_seq_if #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       sel;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] rd;
   logic             busy;

   modport master (
      output in_valid, sel, rs, rt, shamt, out_ready,
      input  in_ready, out_valid, rd, busy
   );

   modport slave (
      input  in_valid, sel, rs, rt, shamt, out_ready,
      output in_ready, out_valid, rd, busy
   );
endinterface

// File: rtl/decode_execute_seq.sv
// Sequential decode-and-execute ALU: one op per handshake, rotates stepped one bit per cycle.
// Define DEX_BARREL_EN to rotate in a single cycle at accept instead (SHIFT is then never entered).
module decode_execute_seq #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   decode_execute_seq_if.slave  bus,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] rd_q, rd_n;
   logic [SHW-1:0]   cnt, cnt_n;
   logic             left_q, left_n;

`ifdef DEX_BARREL_EN
   // Rotate right by amt mod WIDTH via a doubled vector; left is right by the complement.
   function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x,
                                            input logic [SHW-1:0]   amt,
                                            input logic             left);
      logic [2*WIDTH-1:0] d;
      int                 a;
      a = int'(amt) % WIDTH;
      if (left) a = (WIDTH - a) % WIDTH;
      d = {x, x} >> a;
      return d[WIDTH-1:0];
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rd_q   <= '0;
         cnt    <= '0;
         left_q <= 1'b0;
      end else begin
         state  <= state_n;
         rd_q   <= rd_n;
         cnt    <= cnt_n;
         left_q <= left_n;
      end
   end

   always_comb begin
      state_n = state;
      rd_n    = rd_q;
      cnt_n   = cnt;
      left_n  = left_q;
      case (state)
         IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
               state_n = DONE;
               case (bus.sel)
                  3'b000: rd_n = bus.rs - bus.rt;
                  3'b001: rd_n = bus.rs + bus.rt;
                  3'b010: rd_n = bus.rs | bus.rt;
                  3'b011: rd_n = bus.rs & bus.rt;
`ifdef DEX_BARREL_EN
                  3'b100: rd_n = rot(bus.rt, bus.shamt, 1'b0);
                  3'b101: rd_n = rot(bus.rs, bus.shamt, 1'b1);
`else
                  3'b100, 3'b101: begin
                     rd_n   = (bus.sel[0]) ? bus.rs : bus.rt;
                     left_n = bus.sel[0];
                     if (bus.shamt != '0) begin
                        cnt_n   = bus.shamt;
                        state_n = SHIFT;
                     end
                  end
`endif
                  3'b110: begin
                     rd_n      = '0;
                     rd_n[3:0] = {3'b101, (bus.rs < bus.rt)};
                  end
                  default: begin
                     rd_n      = '0;
                     rd_n[3:0] = {3'b111, (bus.rs == bus.rt)};
                  end
               endcase
            end
         end
         SHIFT: begin
            rd_n  = left_q ? {rd_q[WIDTH-2:0], rd_q[WIDTH-1]}
                           : {rd_q[0], rd_q[WIDTH-1:1]};
            cnt_n = cnt - 1'b1;
            // cnt==1 means this step is the last one of the rotate
            if (cnt == {{(SHW-1){1'b0}}, 1'b1}) state_n = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.rd        = rd_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_decode_execute_seq.sv
// Bench for decode_execute_seq: a WIDTH=4 and a WIDTH=8 instance share one random/directed stimulus
// stream; a transaction-level model predicts in_ready/out_valid/busy/rd for each instance every cycle.
module tb_decode_execute_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, out_ready;
   logic [2:0] sel, shamt;
   logic [7:0] rs, rt;
   logic [1:0] dbg4, dbg8;
   bit         started = 1'b0;

   int tests = 0;
   int fails = 0;

`ifdef DEX_BARREL_EN
   localparam int ROT_LAT = 1;
`else
   localparam int ROT_LAT = 4;
`endif

   always #5 clk = ~clk;

   decode_execute_seq_if #(.WIDTH(4)) b4 ();
   decode_execute_seq_if #(.WIDTH(8)) b8 ();

   assign b4.in_valid  = in_valid;
   assign b4.sel       = sel;
   assign b4.rs        = rs[3:0];
   assign b4.rt        = rt[3:0];
   assign b4.shamt     = shamt[1:0];
   assign b4.out_ready = out_ready;
   assign b8.in_valid  = in_valid;
   assign b8.sel       = sel;
   assign b8.rs        = rs;
   assign b8.rt        = rt;
   assign b8.shamt     = shamt;
   assign b8.out_ready = out_ready;

   decode_execute_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave), .dbg_state(dbg4));
   decode_execute_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave), .dbg_state(dbg8));

   logic [7:0] a_rd[2];
   logic       a_ov[2], a_ir[2], a_bs[2];
   assign a_rd[0] = {4'h0, b4.rd};
   assign a_rd[1] = b8.rd;
   assign a_ov[0] = b4.out_valid;
   assign a_ov[1] = b8.out_valid;
   assign a_ir[0] = b4.in_ready;
   assign a_ir[1] = b8.in_ready;
   assign a_bs[0] = b4.busy;
   assign a_bs[1] = b8.busy;

   // Model state per instance: pending op, cycles left before it is visible, its result, last result held
   bit         pend[2];
   int         wt[2];
   logic [7:0] res[2];
   logic [7:0] last[2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         pend[k] = 1'b0;
         wt[k]   = 0;
         res[k]  = 8'h00;
         last[k] = 8'h00;
      end
   end

   function automatic logic [7:0] model_res(input int w, input logic [2:0] s,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input int amt);
      int mask, x, y, r, v;
      mask = (1 << w) - 1;
      x = int'(a) & mask;
      y = int'(b) & mask;
      r = amt % w;
      case (s)
         3'd0:    v = x - y;
         3'd1:    v = x + y;
         3'd2:    v = x | y;
         3'd3:    v = x & y;
         3'd4:    v = (y >> r) | (y << (w - r));
         3'd5:    v = (x << r) | (x >> (w - r));
         3'd6:    v = 10 + ((x < y) ? 1 : 0);
         default: v = 14 + ((x == y) ? 1 : 0);
      endcase
      return 8'(v & mask);
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int w;
         int amt;
         w   = (k == 0) ? 4 : 8;
         amt = (k == 0) ? int'(shamt[1:0]) : int'(shamt);
         if (started) begin
            chk($sformatf("in_ready_w%0d", w), {7'd0, a_ir[k]}, {7'd0, (!pend[k] && !rst)});
            chk($sformatf("busy_w%0d", w), {7'd0, a_bs[k]}, {7'd0, pend[k]});
            chk($sformatf("out_valid_w%0d", w), {7'd0, a_ov[k]}, {7'd0, (pend[k] && wt[k] == 0)});
            if (pend[k] && wt[k] == 0) chk($sformatf("rd_w%0d", w), a_rd[k], res[k]);
            else if (!pend[k])         chk($sformatf("rd_hold_w%0d", w), a_rd[k], last[k]);
         end
         if (rst) begin
            pend[k] = 1'b0;
            last[k] = 8'h00;
         end else if (pend[k]) begin
            if (wt[k] > 0) wt[k] = wt[k] - 1;
            else if (out_ready) begin
               pend[k] = 1'b0;
               last[k] = res[k];
            end
         end else if (in_valid) begin
            pend[k] = 1'b1;
            res[k]  = model_res(w, sel, rs, rt, amt);
`ifdef DEX_BARREL_EN
            wt[k]   = 0;
`else
            wt[k]   = (sel == 3'd4 || sel == 3'd5) ? amt : 0;
`endif
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] sh, input logic ordy);
      int n;
      n = 0;
      tick;
      while ((pend[0] || pend[1]) && n < 64) begin
         out_ready = 1'b1;
         tick;
         n++;
      end
      chk("idle_wait", {7'd0, (pend[0] || pend[1])}, 8'd0);
      sel = s; rs = a; rt = b; shamt = sh;
      out_ready = ordy;
      in_valid  = 1'b1;
      tick;
      in_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      sel = 3'd0; rs = 8'd0; rt = 8'd0; shamt = 3'd0;

      chk("model_sub4",  model_res(4, 3'd0, 8'd3, 8'd5, 0), 8'd14);
      chk("model_add4",  model_res(4, 3'd1, 8'd9, 8'd8, 0), 8'd1);
      chk("model_rotr4", model_res(4, 3'd4, 8'd0, 8'd1, 3), 8'd2);
      chk("model_rotl4", model_res(4, 3'd5, 8'd9, 8'd0, 2), 8'd6);
      chk("model_lt8",   model_res(8, 3'd6, 8'd3, 8'd5, 0), 8'h0B);
      chk("model_eq8",   model_res(8, 3'd7, 8'd7, 8'd8, 0), 8'h0E);

      tick;
      started = 1'b1;
      @(negedge clk);
      chk("rst_in_ready4", {7'd0, b4.in_ready}, 8'd0);
      chk("rst_rd4", {4'd0, b4.rd}, 8'd0);
      chk("rst_rd8", b8.rd, 8'd0);
      chk("rst_state4", {6'd0, dbg4}, 8'd0);
      chk("rst_state8", {6'd0, dbg8}, 8'd0);
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk("release_in_ready4", {7'd0, b4.in_ready}, 8'd1);

      // subtract, then hold the result under backpressure with noise on the inputs
      op(3'd0, 8'd3, 8'd5, 3'd0, 1'b0);
      @(negedge clk);
      chk("sub_valid4", {7'd0, b4.out_valid}, 8'd1);
      chk("sub_rd4", {4'd0, b4.rd}, 8'd14);
      chk("sub_rd8", b8.rd, 8'hFE);
      for (int i = 0; i < 5; i++) begin
         tick;
         in_valid = 1'b1;
         sel = 3'($urandom_range(0, 7));
         rs  = 8'($urandom);
         rt  = 8'($urandom);
         @(negedge clk);
         chk("bp_rd4", {4'd0, b4.rd}, 8'd14);
         chk("bp_in_ready4", {7'd0, b4.in_ready}, 8'd0);
      end
      tick;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      @(negedge clk);
      chk("drain_in_ready4", {7'd0, b4.in_ready}, 8'd1);
      chk("drain_valid4", {7'd0, b4.out_valid}, 8'd0);

      op(3'd1, 8'd9, 8'd8, 3'd0, 1'b1);
      @(negedge clk);
      chk("add_rd4", {4'd0, b4.rd}, 8'd1);

      op(3'd4, 8'd0, 8'd1, 3'd3, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) tick;
         @(negedge clk);
         chk("rotr_valid4", {7'd0, b4.out_valid}, {7'd0, (i == ROT_LAT)});
         if (i == ROT_LAT) chk("rotr_rd4", {4'd0, b4.rd}, 8'd2);
      end

      op(3'd5, 8'd9, 8'd0, 3'd0, 1'b1);
      @(negedge clk);
      chk("rotl0_valid4", {7'd0, b4.out_valid}, 8'd1);
      chk("rotl0_rd4", {4'd0, b4.rd}, 8'd9);

      op(3'd6, 8'd3, 8'd5, 3'd0, 1'b1);
      @(negedge clk);
      chk("lt_rd8", b8.rd, 8'h0B);
      op(3'd6, 8'd5, 8'd3, 3'd0, 1'b1);
      @(negedge clk);
      chk("ge_rd8", b8.rd, 8'h0A);
      op(3'd7, 8'd7, 8'd7, 3'd0, 1'b1);
      @(negedge clk);
      chk("eq_rd8", b8.rd, 8'h0F);
      op(3'd7, 8'd7, 8'd8, 3'd0, 1'b1);
      @(negedge clk);
      chk("ne_rd8", b8.rd, 8'h0E);

      // reset lands in the second SHIFT cycle of a 3-step rotate
      op(3'd5, 8'd5, 8'd0, 3'd3, 1'b1);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready4", {7'd0, b4.in_ready}, 8'd1);
      chk("abort_valid4", {7'd0, b4.out_valid}, 8'd0);
      chk("abort_rd4", {4'd0, b4.rd}, 8'd0);
      op(3'd3, 8'd12, 8'd10, 3'd0, 1'b1);
      @(negedge clk);
      chk("and_rd4", {4'd0, b4.rd}, 8'd8);

`ifdef DEX_BARREL_EN
      op(3'd5, 8'd9, 8'd0, 3'd2, 1'b1);
      @(negedge clk);
      chk("barrel_valid4", {7'd0, b4.out_valid}, 8'd1);
      chk("barrel_rd4", {4'd0, b4.rd}, 8'd6);
      chk("barrel_busy4", {7'd0, b4.busy}, 8'd1);
      tick;
      @(negedge clk);
      chk("barrel_busy_end4", {7'd0, b4.busy}, 8'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         tick;
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         sel       = 3'($urandom_range(0, 7));
         rs        = 8'($urandom);
         rt        = 8'($urandom);
         shamt     = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      tick;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
